// File: rtl/fft_pkg.sv
// Shared constants and state encoding for the FFT frame scheduler.
`include "fft_inc.sv"

package fft_pkg;

  localparam int N = 1 << `TOTAL_STAGE;

  localparam logic [`TOTAL_STAGE-1:0] ADDR_ONES = '1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FILL,
    DROP
  } fft_sched_state_t;

endpackage

// File: rtl/fft_frame_mon.sv
// Tracks frames in flight between the first-stage input and the last-stage output.
// Optional statistics counters are built only when FFT_SCHED_STATS_EN is defined.
`include "fft_inc.sv"

module fft_frame_mon #(
  parameter int TOTAL_STAGE = `TOTAL_STAGE
) (
  input  logic                   iclk,
  input  logic                   rst,
  input  logic                   oen,
  input  logic [TOTAL_STAGE-1:0] oaddr,
  input  logic                   res_en,
  input  logic [TOTAL_STAGE-1:0] res_addr,
  output logic [TOTAL_STAGE:0]   in_flight,
  output logic [15:0]            frames_in,
  output logic [15:0]            frames_out
);

  logic frame_enter;
  logic frame_exit;

  assign frame_enter = oen && (oaddr == '1);
  assign frame_exit  = res_en && (res_addr == '1);

  // Simultaneous enter and exit cancel; both ends saturate.
  always_ff @(posedge iclk) begin
    if (rst) begin
      in_flight <= '0;
    end else if (frame_enter && !frame_exit && (in_flight != '1)) begin
      in_flight <= in_flight + (TOTAL_STAGE+1)'(1);
    end else if (frame_exit && !frame_enter && (in_flight != '0)) begin
      in_flight <= in_flight - (TOTAL_STAGE+1)'(1);
    end
  end

`ifdef FFT_SCHED_STATS_EN
  always_ff @(posedge iclk) begin
    if (rst) begin
      frames_in  <= '0;
      frames_out <= '0;
    end else begin
      if (frame_enter) frames_in  <= frames_in + 16'd1;
      if (frame_exit)  frames_out <= frames_out + 16'd1;
    end
  end
`else
  assign frames_in  = '0;
  assign frames_out = '0;
`endif

endmodule

// File: rtl/fft_inc.sv
// Sizing macros for the FFT front-end: address width (log2 N) and packed complex sample width.
`ifndef FFT_INC_SV
`define FFT_INC_SV

`ifndef TOTAL_STAGE
`define TOTAL_STAGE 4
`endif

`ifndef CPLX_WIDTH
`define CPLX_WIDTH 32
`endif

`endif

// File: rtl/fft_frame_sched.sv
// Forms gapless N-sample frames for the first FFT stage, repairing bad source frames.
// Frame statistics are enabled by defining FFT_SCHED_STATS_EN.
`include "fft_inc.sv"

module fft_frame_sched
  import fft_pkg::*;
#(
  parameter int TOTAL_STAGE = `TOTAL_STAGE,
  parameter int CPLX_WIDTH  = `CPLX_WIDTH
) (
  input  logic                   iclk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [CPLX_WIDTH-1:0]  s_data,
  input  logic                   s_last,
  output logic                   oen,
  output logic [TOTAL_STAGE-1:0] oaddr,
  output logic [CPLX_WIDTH-1:0]  odata,
  input  logic                   res_en,
  input  logic [TOTAL_STAGE-1:0] res_addr,
  input  logic                   clr_err,
  output logic                   err_underrun,
  output logic                   err_short,
  output logic                   err_long,
  output logic                   busy,
  output logic [15:0]            frames_in,
  output logic [15:0]            frames_out
);

  fft_sched_state_t state, state_n;
  logic [TOTAL_STAGE-1:0] cnt, cnt_n;
  logic                   src_open, src_open_n;
  logic                   oen_n;
  logic [TOTAL_STAGE-1:0] oaddr_n;
  logic [CPLX_WIDTH-1:0]  odata_n;
  logic                   set_underrun, set_short, set_long;
  logic                   accept;
  logic                   cnt_last;
  logic [TOTAL_STAGE:0]   in_flight;

  assign s_ready  = !rst && (((state == IDLE) && enable) || (state == RUN) || (state == DROP));
  assign accept   = s_valid && s_ready;
  assign cnt_last = (cnt == '1);

  // src_open remembers whether the source still owes the rest of its frame,
  // so FILL knows whether to drain it through DROP afterwards.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    src_open_n   = src_open;
    oen_n        = 1'b0;
    oaddr_n      = '1;
    odata_n      = '0;
    set_underrun = 1'b0;
    set_short    = 1'b0;
    set_long     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          oen_n      = 1'b1;
          oaddr_n    = '0;
          odata_n    = s_data;
          cnt_n      = TOTAL_STAGE'(1);
          src_open_n = 1'b0;
          if (s_last) begin
            set_short = 1'b1;
            state_n   = FILL;
          end else begin
            state_n = RUN;
          end
        end
      end
      RUN: begin
        oen_n   = 1'b1;
        oaddr_n = cnt;
        if (accept) begin
          odata_n = s_data;
          if (cnt_last) begin
            cnt_n = '0;
            if (s_last) begin
              state_n = IDLE;
            end else begin
              set_long = 1'b1;
              state_n  = DROP;
            end
          end else begin
            cnt_n = cnt + TOTAL_STAGE'(1);
            if (s_last) begin
              set_short  = 1'b1;
              src_open_n = 1'b0;
              state_n    = FILL;
            end
          end
        end else begin
          set_underrun = 1'b1;
          if (cnt_last) begin
            cnt_n   = '0;
            state_n = DROP;
          end else begin
            cnt_n      = cnt + TOTAL_STAGE'(1);
            src_open_n = 1'b1;
            state_n    = FILL;
          end
        end
      end
      FILL: begin
        oen_n   = 1'b1;
        oaddr_n = cnt;
        if (cnt_last) begin
          cnt_n   = '0;
          state_n = src_open ? DROP : IDLE;
        end else begin
          cnt_n = cnt + TOTAL_STAGE'(1);
        end
      end
      DROP: begin
        if (accept && s_last) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // A flag being set outranks a clear arriving in the same cycle.
  always_ff @(posedge iclk) begin
    if (rst) begin
      state        <= IDLE;
      cnt          <= '0;
      src_open     <= 1'b0;
      oen          <= 1'b0;
      oaddr        <= '1;
      odata        <= '0;
      err_underrun <= 1'b0;
      err_short    <= 1'b0;
      err_long     <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      src_open     <= src_open_n;
      oen          <= oen_n;
      oaddr        <= oaddr_n;
      odata        <= odata_n;
      err_underrun <= set_underrun || (err_underrun && !clr_err);
      err_short    <= set_short    || (err_short    && !clr_err);
      err_long     <= set_long     || (err_long     && !clr_err);
    end
  end

  fft_frame_mon #(
    .TOTAL_STAGE(TOTAL_STAGE)
  ) u_mon (
    .iclk      (iclk),
    .rst       (rst),
    .oen       (oen),
    .oaddr     (oaddr),
    .res_en    (res_en),
    .res_addr  (res_addr),
    .in_flight (in_flight),
    .frames_in (frames_in),
    .frames_out(frames_out)
  );

  assign busy = (state != IDLE) || (in_flight != '0);

endmodule

// File: tb/tb_fft_frame_sched.sv
// Scoreboard bench for fft_frame_sched at N=16: directed frames push expected
// first-stage beats into a queue, a negedge monitor pops and compares them.
module tb_fft_frame_sched;

  localparam int TS = 4;
  localparam int NS = 16;
  localparam int CW = 32;
`ifdef FFT_SCHED_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          iclk;
  logic          rst;
  logic          enable;
  logic          s_valid;
  logic          s_ready;
  logic [CW-1:0] s_data;
  logic          s_last;
  logic          oen;
  logic [TS-1:0] oaddr;
  logic [CW-1:0] odata;
  logic          res_en;
  logic [TS-1:0] res_addr;
  logic          clr_err;
  logic          err_underrun;
  logic          err_short;
  logic          err_long;
  logic          busy;
  logic [15:0]   frames_in;
  logic [15:0]   frames_out;

  typedef struct {
    logic [TS-1:0] addr;
    logic [CW-1:0] data;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   run_len = 0;
  int   last_run = 0;
  int   exp_in = 0;
  int   exp_out = 0;

  fft_frame_sched #(
    .TOTAL_STAGE(TS),
    .CPLX_WIDTH (CW)
  ) dut (
    .iclk        (iclk),
    .rst         (rst),
    .enable      (enable),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .s_data      (s_data),
    .s_last      (s_last),
    .oen         (oen),
    .oaddr       (oaddr),
    .odata       (odata),
    .res_en      (res_en),
    .res_addr    (res_addr),
    .clr_err     (clr_err),
    .err_underrun(err_underrun),
    .err_short   (err_short),
    .err_long    (err_long),
    .busy        (busy),
    .frames_in   (frames_in),
    .frames_out  (frames_out)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge iclk) begin
    if (oen === 1'b1) begin
      run_len++;
      if (expq.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_beat: got addr %0d data %0h, expected no output", oaddr, odata);
      end else begin
        mon_e = expq.pop_front();
        checkOutput("beat_addr", 64'(oaddr), 64'(mon_e.addr));
        checkOutput("beat_data", 64'(odata), 64'(mon_e.data));
      end
    end else begin
      if (run_len != 0) last_run = run_len;
      run_len = 0;
      checkOutput("idle_encoding", {28'd0, oen, oaddr, odata}, {29'd0, 4'hF, 32'd0});
    end
  end

  task automatic pushData(input int a0, input int a1, input int d0);
    exp_t e;
    for (int a = a0; a <= a1; a++) begin
      e.addr = TS'(a);
      e.data = CW'(d0 + a - a0);
      expq.push_back(e);
    end
  endtask

  task automatic pushZeros(input int a0, input int a1);
    exp_t e;
    for (int a = a0; a <= a1; a++) begin
      e.addr = TS'(a);
      e.data = '0;
      expq.push_back(e);
    end
  endtask

  task automatic applyStimulus(input int data, input bit last);
    bit acc;
    int guard;
    acc   = 1'b0;
    guard = 0;
    s_valid = 1'b1;
    s_data  = CW'(data);
    s_last  = last;
    while (!acc && guard < 100) begin
      @(negedge iclk);
      acc = s_ready;
      @(posedge iclk);
      #1;
      guard++;
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("[TB] FAIL beat_accept_timeout: got no s_ready, expected accept of %0d", data);
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  task automatic sendBeats(input int first, input int count, input bit last_on_final);
    for (int i = 0; i < count; i++)
      applyStimulus(first + i, last_on_final && (i == count - 1));
  endtask

  task automatic waitIdle();
    int guard;
    guard = 0;
    while (!(expq.size() == 0 && oen === 1'b0) && guard < 300) begin
      @(negedge iclk);
      guard++;
    end
    if (guard >= 300) begin
      checks++;
      errors++;
      $display("[TB] FAIL wait_idle_timeout: got %0d pending beats, expected 0", expq.size());
    end
    @(posedge iclk);
    #1;
  endtask

  task automatic pulseRes();
    res_en   = 1'b1;
    res_addr = 4'hF;
    @(posedge iclk);
    #1;
    res_en   = 1'b0;
    res_addr = 4'h0;
    exp_out++;
  endtask

  task automatic clearErr();
    clr_err = 1'b1;
    @(posedge iclk);
    #1;
    clr_err = 1'b0;
  endtask

  task automatic checkFlags(input string tag, input bit u, input bit s, input bit l);
    checkOutput({tag, "_flags"}, {61'd0, err_underrun, err_short, err_long}, {61'd0, u, s, l});
  endtask

  task automatic checkCounters(input string tag);
    checkOutput({tag, "_frames_in"},  64'(frames_in),  STATS ? 64'(exp_in[15:0])  : 64'd0);
    checkOutput({tag, "_frames_out"}, 64'(frames_out), STATS ? 64'(exp_out[15:0]) : 64'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; enable = 1'b1; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    res_en = 1'b0; res_addr = '0; clr_err = 1'b0;

    // Reset state
    repeat (2) @(posedge iclk);
    #1;
    checkOutput("s_ready_in_reset", 64'(s_ready), 64'd0);
    rst = 1'b0;
    @(negedge iclk);
    checkOutput("reset_outputs", {27'd0, oen, oaddr, odata}, {28'd0, 4'hF, 32'd0});
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkFlags("reset", 0, 0, 0);
    checkCounters("reset");
    @(posedge iclk);
    #1;

    // Two back-to-back clean frames
    pushData(0, 15, 1);
    pushData(0, 15, 17);
    exp_in += 2;
    sendBeats(1, 16, 1);
    sendBeats(17, 16, 1);
    waitIdle();
    checkOutput("clean_run_len", 64'(last_run), 64'd32);
    checkFlags("clean", 0, 0, 0);
    checkCounters("clean");
    checkOutput("clean_busy_in_flight", 64'(busy), 64'd1);
    pulseRes();
    pulseRes();
    @(negedge iclk);
    checkOutput("clean_busy_drained", 64'(busy), 64'd0);
    checkCounters("clean_drained");
    @(posedge iclk);
    #1;

    // Underrun after beat 5, remainder of source frame dropped
    pushData(0, 4, 41);
    pushZeros(5, 15);
    exp_in++;
    sendBeats(41, 5, 0);
    @(posedge iclk);
    #1;
    @(negedge iclk);
    checkOutput("s_ready_fill", 64'(s_ready), 64'd0);
    sendBeats(46, 11, 1);
    waitIdle();
    checkFlags("underrun", 1, 0, 0);
    clearErr();
    checkFlags("underrun_cleared", 0, 0, 0);
    pulseRes();
    @(negedge iclk);
    checkOutput("underrun_busy", 64'(busy), 64'd0);
    checkCounters("underrun");
    @(posedge iclk);
    #1;

    // Short frame (clear coincident with set), then an immediate clean frame
    pushData(0, 9, 61);
    pushZeros(10, 15);
    pushData(0, 15, 81);
    exp_in += 2;
    sendBeats(61, 9, 0);
    clr_err = 1'b1;
    applyStimulus(70, 1);
    clr_err = 1'b0;
    sendBeats(81, 16, 1);
    waitIdle();
    checkFlags("short", 0, 1, 0);
    clearErr();
    checkFlags("short_cleared", 0, 0, 0);
    checkOutput("short_busy", 64'(busy), 64'd1);

    // Long frame with a result pulse coincident with its completion
    pushData(0, 15, 121);
    exp_in++;
    sendBeats(121, 16, 0);
    res_en   = 1'b1;
    res_addr = 4'hF;
    applyStimulus(137, 0);
    res_en   = 1'b0;
    res_addr = 4'h0;
    exp_out++;
    sendBeats(138, 3, 1);
    waitIdle();
    checkFlags("long", 0, 0, 1);
    pulseRes();
    @(negedge iclk);
    checkOutput("long_busy_one_left", 64'(busy), 64'd1);
    @(posedge iclk);
    #1;
    pulseRes();
    @(negedge iclk);
    checkOutput("long_busy_drained", 64'(busy), 64'd0);
    checkCounters("long");
    @(posedge iclk);
    #1;
    clearErr();

    // Reset in the middle of a frame at address 7
    pushData(0, 7, 201);
    sendBeats(201, 8, 0);
    rst = 1'b1;
    @(negedge iclk);
    checkOutput("s_ready_mid_reset", 64'(s_ready), 64'd0);
    @(posedge iclk);
    #1;
    rst = 1'b0;
    exp_in  = 0;
    exp_out = 0;
    @(negedge iclk);
    checkOutput("midreset_outputs", {27'd0, oen, oaddr, odata}, {28'd0, 4'hF, 32'd0});
    checkOutput("midreset_busy", 64'(busy), 64'd0);
    checkFlags("midreset", 0, 0, 0);
    checkCounters("midreset");
    @(posedge iclk);
    #1;

    pushData(0, 15, 221);
    exp_in++;
    sendBeats(221, 16, 1);
    waitIdle();
    checkFlags("post_reset", 0, 0, 0);
    checkCounters("post_reset");
    checkOutput("leftover_expected", 64'(expq.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
